// File: rtl/fetch_pkg.sv
// Shared constants and FSM state type for the fetch stage.
package fetch_pkg;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] JUMP_OP = 6'b010111;
  localparam logic [OPCODE_W-1:0] HALT_OP = 6'b111111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: redirect beats early jump, which beats wrapping increment.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] next_pc_c
);

  always_comb begin
    next_pc_c = pc + ADDR_WIDTH'(1);
    if (redirect_valid) begin
      next_pc_c = redirect_pc;
    end else if (opcode == JUMP_OP) begin
      next_pc_c = jump_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC/fetch stage feeding decode through a valid/ready instruction register.
// Optional halt-opcode support is compiled in with FETCH_HALT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  addy,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   halted
);

  localparam int unsigned CNT_W = 4;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       boot_cnt_q, boot_cnt_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
  logic                   valid_q, valid_d;
  logic                   load_c;
  logic [ADDR_WIDTH-1:0]  next_pc_c;

  fetch_next_pc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_next_pc (
    .pc             (pc_q),
    .opcode         (mem_data[OPCODE_MSB:OPCODE_LSB]),
    .jump_target    (mem_data[ADDR_WIDTH-1:0]),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc_c      (next_pc_c)
  );

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign addy        = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pc_q       <= ADDR_WIDTH'(RESET_PC);
      instr_q    <= '0;
      ipc_q      <= '0;
      valid_q    <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      valid_q    <= valid_d;
`ifdef FETCH_HALT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    valid_d    = valid_q;
`ifdef FETCH_HALT_EN
    halted_d   = halted_q;
`endif
    load_c = (state_q == RUN) && !redirect_valid && (!valid_q || instr_ready);

    // Drain: any cycle that consumes the register without refilling it.
    if (instr_ready && !load_c) begin
      valid_d = 1'b0;
    end

    case (state_q)
      BOOT: begin
        if (boot_cnt_q == CNT_W'(BOOT_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d    = next_pc_c;
          valid_d = 1'b0;
        end else if (load_c) begin
          instr_d = mem_data;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = next_pc_c;
`ifdef FETCH_HALT_EN
          if (mem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OP) begin
            pc_d     = pc_q;
            state_d  = HALT;
            halted_d = 1'b1;
          end
`endif
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed programs, expected deliveries queued up front.
module tb_fetch_unit;

  typedef struct packed {
    logic [9:0]  pc;
    logic [31:0] instr;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  addy;
  logic [31:0] mem_data;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic [31:0] instr_out;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        halted;

  logic [31:0] mem [1024];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clock = ~clock;

  assign mem_data = mem[addy];

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .addy           (addy),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .halted         (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seq_word(input int i);
    return {6'b000001, 26'(i)};
  endfunction

  task automatic fill_seq();
    for (int i = 0; i < 1024; i++) mem[i] = seq_word(i);
  endtask

  task automatic expect_pc(input int p);
    exp_q.push_back({10'(p), mem[p]});
  endtask

  task automatic start();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Mid-run reset must clear outputs immediately, and every expected delivery must have occurred.
  task automatic finish_scn(input string name);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_rst_valid"}, 32'(instr_valid), 32'd0);
    chk({name, "_rst_addy"}, 32'(addy), 32'd0);
    chk({name, "_rst_halted"}, 32'(halted), 32'd0);
    exp_q.delete();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer_pc", 32'(instr_pc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_pc", 32'(instr_pc), 32'(e.pc));
        chk("xfer_instr", instr_out, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_seq();
    #1 reset = 1'b1;
    #10;
    chk("rst_addy", 32'(addy), 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Sequential fetch with boot delay.
    fill_seq();
    for (int p = 0; p < 4; p++) expect_pc(p);
    start();
    edges(1);
    chk("boot_edge1_valid", 32'(instr_valid), 32'd0);
    edges(1);
    chk("boot_edge2_valid", 32'(instr_valid), 32'd1);
    chk("boot_edge2_pc", 32'(instr_pc), 32'd0);
    edges(3);
    finish_scn("seq");

    // Early jump 0 -> 3, no penalty.
    fill_seq();
    mem[0] = 32'h5C00_0003;
    expect_pc(0); expect_pc(3); expect_pc(4);
    start();
    edges(2);
    chk("jump_addy", 32'(addy), 32'd3);
    edges(2);
    finish_scn("jump");

    // Stall holding pc 5 for three cycles.
    fill_seq();
    for (int p = 0; p < 7; p++) expect_pc(p);
    start();
    edges(7);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      chk("stall_pc", 32'(instr_pc), 32'd5);
      chk("stall_instr", instr_out, seq_word(5));
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_addy", 32'(addy), 32'd6);
    end
    instr_ready = 1'b1;
    edges(1);
    finish_scn("stall");

    // Redirect to 100 beats the jump sitting at pc 7.
    fill_seq();
    mem[7] = {6'b010111, 26'd20};
    for (int p = 0; p < 7; p++) expect_pc(p);
    expect_pc(100); expect_pc(101);
    start();
    edges(8);
    redirect_valid = 1'b1;
    redirect_pc    = 10'd100;
    edges(1);
    redirect_valid = 1'b0;
    chk("redir_bubble", 32'(instr_valid), 32'd0);
    chk("redir_addy", 32'(addy), 32'd100);
    edges(1);
    chk("redir_target_valid", 32'(instr_valid), 32'd1);
    chk("redir_target_pc", 32'(instr_pc), 32'd100);
    edges(1);
    finish_scn("redirect");

    // Redirect during BOOT is ignored; then wrap from 1023 to 0.
    fill_seq();
    expect_pc(0); expect_pc(1023); expect_pc(0); expect_pc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 10'd500;
    start();
    edges(1);
    redirect_valid = 1'b0;
    edges(1);
    redirect_valid = 1'b1;
    redirect_pc    = 10'd1023;
    edges(1);
    redirect_valid = 1'b0;
    edges(3);
    finish_scn("wrap");

    // Halt opcode at word 2.
    fill_seq();
    mem[2] = 32'hFC00_0002;
`ifdef FETCH_HALT_EN
    expect_pc(0); expect_pc(1); expect_pc(2);
    start();
    edges(4);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_addy", 32'(addy), 32'd2);
    for (int i = 0; i < 20; i++) begin
      edges(1);
      redirect_valid = (i == 5);
      redirect_pc    = 10'd100;
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_held", 32'(halted), 32'd1);
      chk("halt_pc_hold", 32'(addy), 32'd2);
    end
    finish_scn("halt");
`else
    for (int p = 0; p < 4; p++) expect_pc(p);
    start();
    edges(5);
    chk("nohalt_flag", 32'(halted), 32'd0);
    chk("nohalt_addy", 32'(addy), 32'd4);
    finish_scn("nohalt");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
